// File: rtl/wide_add_seq.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice of full_adder cells is
// time-multiplexed across WIDTH/4 nibbles, with a registered carry between them.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic cout,
   output logic s
);
   assign s    = a ^ b ^ c;
   assign cout = (a & b) | (c & (a ^ b));
endmodule

module wide_add_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic [IW-1:0]    idx;
   logic [3:0]       slice_a, slice_b, slice_s;
   logic [4:0]       chain;
   logic             last;

   // Nibble select by constant part-selects so every index stays in range.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (idx == IW'(i)) begin
            slice_a = a_q[4*i +: 4];
            slice_b = b_q[4*i +: 4];
         end
      end
   end

   assign chain[0] = carry_q;

   for (genvar g = 0; g < 4; g++) begin : g_fa
      full_adder u_fa (
         .a   (slice_a[g]),
         .b   (slice_b[g]),
         .c   (chain[g]),
         .cout(chain[g+1]),
         .s   (slice_s[g])
      );
   end

   assign last = (idx == IW'(NSLICE - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (last)  state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  idx     <= '0;
               end
            end
            RUN: begin
               carry_q <= chain[4];
               for (int unsigned i = 0; i < NSLICE; i++) begin
                  if (idx == IW'(i)) sum[4*i +: 4] <= slice_s;
               end
               if (last) cout <= chain[4];
               else      idx  <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed cases plus random operands
// compared against plain {cout,sum} = a + b + cin arithmetic.

module tb_wide_add_seq;
   logic        clk = 1'b0;
   logic        rst, start, cin;
   logic [15:0] a, b;
   logic        ready, busy, done, cout;
   logic [15:0] sum;

   logic        start4, cin4;
   logic [3:0]  a4, b4;
   logic        ready4, busy4, done4, cout4;
   logic [3:0]  sum4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wide_add_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   wide_add_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation, scramble the inputs afterwards, and check the result.
   task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc);
      logic [16:0] exp;
      int          n;
      exp   = {1'b0, xa} + {1'b0, xb} + {16'd0, xc};
      a     = xa;
      b     = xb;
      cin   = xc;
      start = 1'b1;
      step();
      start = 1'b0;
      a     = ~xa;
      b     = ~xb;
      cin   = ~xc;
      n     = 0;
      while (busy && n < 20) begin
         n++;
         step();
      end
      check({tag, " busy_cycles"}, n, 4);
      check({tag, " done"}, done, 1);
      check({tag, " result"}, {cout, sum}, exp);
      step();
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " hold_sum"}, sum, exp[15:0]);
   endtask

   initial begin
      int d, cyc, last_cyc, pulses;
      rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

      // Reset with start held high
      step();
      step();
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 16'h0000);
      check("rst_cout", cout, 0);
      rst = 1'b0; start = 1'b0;
      step();
      check("idle_ready", ready, 1);

      run_op("basic", 16'h0003, 16'h000B, 1'b0);
      run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0);
      run_op("ripple2", 16'hFFFF, 16'h0000, 1'b1);

      // Capture / ignore start while busy
      a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      a = 16'hFFFF; start = 1'b1;
      step();
      check("ign_ready_low", ready, 0);
      start = 1'b0;
      d = 0;
      while (busy && d < 20) begin d++; step(); end
      check("ign_done", done, 1);
      check("ign_result", {cout, sum}, 17'h05556);
      step();
      d = 0;
      repeat (8) begin if (done) d++; step(); end
      check("ign_no_second_done", d, 0);

      // Reset mid-operation, sampled at E2
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_ready", ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_sum", sum, 16'h0000);
      d = 0;
      repeat (6) begin if (done) d++; step(); end
      check("midrst_no_done", d, 0);
      run_op("after_rst", 16'h00FF, 16'h0001, 1'b0);

      // Back-to-back with start held high
      a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
      cyc = 0; last_cyc = -1; pulses = 0;
      while (pulses < 3 && cyc < 100) begin
         if (done) begin
            check("b2b_result", {cout, sum}, 17'h10000);
            if (last_cyc >= 0) check("b2b_interval", cyc - last_cyc, 6);
            last_cyc = cyc;
            pulses++;
         end
         step();
         cyc++;
      end
      check("b2b_pulses", pulses, 3);
      start = 1'b0;
      repeat (8) step();

      // Random operands against the arithmetic model
      for (int i = 0; i < 20; i++) begin
         run_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
      end

      // WIDTH=4 degenerate case
      a4 = 4'hA; b4 = 4'h7; cin4 = 1'b0; start4 = 1'b1;
      step();
      start4 = 1'b0;
      check("w4_busy", busy4, 1);
      step();
      check("w4_done", done4, 1);
      check("w4_result", {cout4, sum4}, 5'h11);
      step();
      check("w4_ready", ready4, 1);
      check("w4_done_low", done4, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
